sprite_attr_bank: RTL

Parametrised, Avalon-MM-mapped sprite attribute table. It replaces the per-object PIO exports (enable, x, y, dir) with one block holding NUM_SPRITES entries. Software writes shadow registers. A commit request copies the shadow set into the active set on the next frame-start pulse, so the renderer never sees a half-updated scene. The block also adds per-sprite animation frame counters stepped by vsync, which the PIO version did not have. It sits between the Nios data master and the sprite renderer / VGA path.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_anim_ctr.sv | 24 ++
 rtl/sprite_attr_bank.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared field positions and attribute record for the sprite attribute bank.
// Coordinates are held at their widest legal size; modules use the low COORD_W bits.
package sprite_pkg;

  localparam int EN_BIT          = 31;
  localparam int DIR_BIT         = 30;
  localparam int ANIM_BIT        = 29;
  localparam int Y_LSB           = 16;
  localparam int CTRL_COMMIT_BIT = 0;
  localparam int COORD_MAX       = 16;

  typedef struct packed {
    logic                 en;
    logic                 dir;
    logic                 anim_en;
    logic [COORD_MAX-1:0] x;
    logic [COORD_MAX-1:0] y;
  } sprite_attr_t;

endpackage

// File: rtl/sprite_anim_ctr.sv
// Per-sprite animation frame counter: steps on tick while enabled and animating.
// Registered output, one-cycle update; held at 0 whenever the sprite is disabled.
module sprite_anim_ctr #(
  parameter int FRAME_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               en,
  input  logic               anim_en,
  output logic [FRAME_W-1:0] frame
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= '0;
    end else if (!en) begin
      frame <= '0;
    end else if (tick && anim_en) begin
      frame <= frame + FRAME_W'(1);
    end
  end

endmodule

// File: rtl/sprite_attr_bank.sv
// Avalon-MM sprite table: shadow entries copied to active on a committed frame start.
// Reads have fixed 1-cycle latency; no waitrequest, every access is accepted.
module sprite_attr_bank
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int ADDR_W      = 5,
  parameter int COORD_W     = 10,
  parameter int FRAME_W     = 2,
  parameter int ANIM_DIV    = 8
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic [ADDR_W-1:0]              avs_address,
  input  logic                           avs_write,
  input  logic [31:0]                    avs_writedata,
  input  logic                           avs_read,
  output logic [31:0]                    avs_readdata,
  input  logic                           vsync_start,
  output logic [NUM_SPRITES-1:0]         sprite_en,
  output logic [NUM_SPRITES-1:0]         sprite_dir,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  output logic [NUM_SPRITES*FRAME_W-1:0] sprite_frame,
  output logic                           commit_pending,
  output logic [15:0]                    frame_count
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_SPRITES);
  localparam int                DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ANIM_DIV - 1);

  function automatic logic [31:0] attr_to_word(sprite_attr_t a);
    logic [31:0] w;
    w                      = '0;
    w[COORD_MAX-1:0]       = a.x;
    w[Y_LSB +: COORD_MAX]  = a.y;
    w[EN_BIT]              = a.en;
    w[DIR_BIT]             = a.dir;
    w[ANIM_BIT]            = a.anim_en;
    return w;
  endfunction

  sprite_attr_t           shadow [NUM_SPRITES];
  sprite_attr_t           wr_attr;
  logic [NUM_SPRITES-1:0] act_en, act_dir, act_anim;
  logic [COORD_W-1:0]     act_x [NUM_SPRITES];
  logic [COORD_W-1:0]     act_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] shd_en, shd_anim, nxt_en, nxt_anim;
  logic [DIV_W-1:0]       div_cnt;
  logic [31:0]            rd_word;
  logic                   commit_fire, ctrl_wr, anim_tick;
  logic                   unused_wdat;

  assign commit_fire = vsync_start & commit_pending;
  assign ctrl_wr     = avs_write & (avs_address == CTRL_ADDR);
  assign anim_tick   = vsync_start & (div_cnt == DIV_LAST);
  assign unused_wdat = &{1'b0, avs_writedata};

  always_comb begin
    wr_attr                    = '0;
    wr_attr.en                 = avs_writedata[EN_BIT];
    wr_attr.dir                = avs_writedata[DIR_BIT];
    wr_attr.anim_en            = avs_writedata[ANIM_BIT];
    wr_attr.x[COORD_W-1:0]     = avs_writedata[COORD_W-1:0];
    wr_attr.y[COORD_W-1:0]     = avs_writedata[Y_LSB +: COORD_W];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (avs_write && avs_address == ADDR_W'(i)) shadow[i] <= wr_attr;
      end
    end
  end

  // Active takes the pre-write shadow, so a coincident write waits for the next commit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      act_en   <= '0;
      act_dir  <= '0;
      act_anim <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
    end else if (commit_fire) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        act_en[i]   <= shadow[i].en;
        act_dir[i]  <= shadow[i].dir;
        act_anim[i] <= shadow[i].anim_en;
        act_x[i]    <= shadow[i].x[COORD_W-1:0];
        act_y[i]    <= shadow[i].y[COORD_W-1:0];
      end
    end
  end

  // A request landing on a frame start survives the clear and waits for the next one.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      commit_pending <= 1'b0;
    end else if (ctrl_wr && avs_writedata[CTRL_COMMIT_BIT]) begin
      commit_pending <= 1'b1;
    end else if (commit_fire) begin
      commit_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt     <= '0;
      frame_count <= '0;
    end else if (vsync_start) begin
      div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      frame_count <= frame_count + 16'd1;
    end
  end

  always_comb begin
    rd_word = '0;
    if (avs_address == CTRL_ADDR) rd_word = {frame_count, 15'b0, commit_pending};
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (avs_address == ADDR_W'(i)) rd_word = attr_to_word(shadow[i]);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_word;
    end
  end

  // Counters see the values being committed this cycle, not the stale active set.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      shd_en[i]   = shadow[i].en;
      shd_anim[i] = shadow[i].anim_en;
    end
  end

  assign nxt_en   = commit_fire ? shd_en   : act_en;
  assign nxt_anim = commit_fire ? shd_anim : act_anim;

  assign sprite_en  = act_en;
  assign sprite_dir = act_dir;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    assign sprite_x[g*COORD_W +: COORD_W] = act_x[g];
    assign sprite_y[g*COORD_W +: COORD_W] = act_y[g];

    sprite_anim_ctr #(
      .FRAME_W (FRAME_W)
    ) u_anim_ctr (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .tick    (anim_tick),
      .en      (nxt_en[g]),
      .anim_en (nxt_anim[g]),
      .frame   (sprite_frame[g*FRAME_W +: FRAME_W])
    );
  end

endmodule
